// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the core's instruction-fetch
// port and its load/store port. Accesses are serialised, at most one read is
// outstanding, and each read response is steered back to the requester that
// issued it. Data accesses win over fetches. The build macro
// MEM_ARB_STARVE_GUARD_EN adds a guard that forces a fetch grant after
// STARVE_LIMIT consecutive data grants made while a fetch was waiting.
//
// Parameters:
//   STARVE_LIMIT  data grants allowed while a fetch waits (guard builds only)
//   CNT_W         starvation counter width, must hold STARVE_LIMIT
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_gnt), address
//   if_gnt/if_rvalid/if_rdata     fetch grant, read valid strobe, read data
//   d_req/d_we/d_be/d_addr/d_wdata  data request and access attributes
//   d_gnt/d_rvalid/d_rdata        data grant, read valid strobe, read data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  memory command
//   mem_ready                     memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata          memory read response (latency >= 1)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t state, state_next;
    logic   owner, owner_next;   // owner of the outstanding read: 1 = data, 0 = fetch
    logic   force_fetch;

    // Elaboration-time guard against a counter too narrow to reach the limit.
    if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_cfg_check
        $error("mem_port_arbiter: CNT_W cannot hold STARVE_LIMIT");
    end

    // Read data is shared; only the rvalid strobes say who it belongs to.
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    // Counts data grants that overtook a waiting fetch; any gap in the fetch
    // request or a fetch grant restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_fetch = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign force_fetch = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers; blocking here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        owner_next = owner;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;

        case (state)
            IDLE: begin
                // Grants are also held off while reset is asserted so the
                // outputs read as zero during reset regardless of requests.
                if (rst_n && mem_ready) begin
                    if (d_req && !(if_req && force_fetch)) begin
                        d_gnt     = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = d_we;
                        mem_be    = d_we ? d_be : 4'b1111;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        if (!d_we) begin
                            state_next = RD_WAIT;
                            owner_next = 1'b1;
                        end
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        mem_req    = 1'b1;
                        mem_be     = 4'b1111;
                        mem_addr   = if_addr;
                        state_next = RD_WAIT;
                        owner_next = 1'b0;
                    end
                end
            end

            RD_WAIT: begin
                // No grant in the response cycle; the next one can issue a cycle later.
                if (mem_rvalid) begin
                    state_next = IDLE;
                    if (owner) begin
                        d_rvalid = 1'b1;
                    end else begin
                        if_rvalid = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A small memory responder answers
// accepted reads after a programmable latency with data from mem_model().
// Each read the bench expects to be granted pushes {owner, data} onto a
// scoreboard; every rvalid strobe pops and compares it. Compile with
// +define+MEM_ARB_STARVE_GUARD_EN to exercise the starvation guard.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        owner;   // 1 = data, 0 = fetch
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Responder state
    int          rsp_lat  = 2;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = 32'h0;
    int          cyc      = 0;

    // Per-cycle snapshot, taken at the falling edge
    logic        s_if_gnt, s_d_gnt, s_if_rv, s_d_rv;
    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic [73:0] s_vec;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    // One clock: sample at the falling edge, score rvalids, note accepted
    // reads, then advance the responder just after the rising edge.
    task automatic cycle();
        exp_t        e;
        logic        got_owner;
        logic [31:0] got_data;
        @(negedge clk);
        s_if_gnt = if_gnt;
        s_d_gnt  = d_gnt;
        s_if_rv  = if_rvalid;
        s_d_rv   = d_rvalid;
        s_req    = mem_req;
        s_we     = mem_we;
        s_be     = mem_be;
        s_addr   = mem_addr;
        s_wdata  = mem_wdata;
        s_vec    = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we,
                    mem_be, mem_addr, mem_wdata};
        if (if_rvalid || d_rvalid) begin
            n_checks++;
            if (sb.size() == 0 || (if_rvalid && d_rvalid)) begin
                $display("FAIL rvalid_unexpected: if_rvalid=%0b d_rvalid=%0b pending=%0d",
                         if_rvalid, d_rvalid, sb.size());
            end else begin
                e         = sb.pop_front();
                got_owner = d_rvalid;
                got_data  = d_rvalid ? d_rdata : if_rdata;
                if (got_owner !== e.owner || got_data !== e.data)
                    $display("FAIL rsp_route: got owner=%0b data=%h, want owner=%0b data=%h",
                             got_owner, got_data, e.owner, e.data);
                else
                    n_pass++;
            end
        end
        if (mem_req && mem_ready && !mem_we) begin
            rsp_wait = rsp_lat;
            rsp_data = mem_model(mem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hCAFE_0000 + cyc;
        if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_data;
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (sb.size() != 0 && k < max_cycles) begin
            cycle();
            k++;
        end
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL drain_timeout: pending=%0d, want 0 after %0d cycles", sb.size(), max_cycles);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        // Outputs during reset with no requests
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 74'h0)
            $display("FAIL reset_outputs: got %h, want 0",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata});
        else
            n_pass++;
        n_checks++;
        if (if_rdata !== 32'h1234_5678 || d_rdata !== 32'h1234_5678)
            $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, want 12345678", if_rdata, d_rdata);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle();
        n_checks++;
        if (s_vec !== 74'h0) $display("FAIL idle_outputs: got %h, want 0", s_vec);
        else n_pass++;

        // Start a fetch read, then reset while it is outstanding
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        cycle();
        n_checks++;
        if (s_if_gnt !== 1'b1) $display("FAIL rst_setup_gnt: if_gnt=%0b, want 1", s_if_gnt);
        else n_pass++;
        if_req   = 1'b0;
        rsp_wait = 0;          // the response is driven by hand below
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;     // late response, one cycle after release
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 74'h0)
            $display("FAIL rst_late_rvalid: outputs=%h, want 0",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata});
        else
            n_pass++;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;

        // FSM must be back in IDLE: a new fetch is granted at once
        if_req  = 1'b1;
        if_addr = 32'h0000_0204;
        cycle();
        n_checks++;
        if (s_if_gnt !== 1'b1 || s_addr !== 32'h0000_0204)
            $display("FAIL rst_idle_gnt: if_gnt=%0b addr=%h, want 1/00000204", s_if_gnt, s_addr);
        else
            n_pass++;
        if (s_if_gnt) sb.push_back('{owner: 1'b0, data: mem_model(32'h0000_0204)});
        if_req = 1'b0;
        drain(10);
    endtask

    task automatic test_single_fetch();
        rsp_lat = 2;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        cycle();   // cycle 0
        n_checks++;
        if (!(s_if_gnt === 1'b1 && s_req === 1'b1 && s_addr === 32'h0000_0100 &&
              s_we === 1'b0 && s_be === 4'b1111 && s_d_gnt === 1'b0))
            $display("FAIL fetch_issue: gnt=%0b req=%0b addr=%h we=%0b be=%b d_gnt=%0b, want 1 1 00000100 0 1111 0",
                     s_if_gnt, s_req, s_addr, s_we, s_be, s_d_gnt);
        else
            n_pass++;
        if (s_if_gnt) sb.push_back('{owner: 1'b0, data: 32'hDEAD_BEEF});
        if_req = 1'b0;
        cycle();   // cycle 1
        n_checks++;
        if (s_if_rv !== 1'b0 || s_d_rv !== 1'b0 || s_req !== 1'b0)
            $display("FAIL fetch_wait: if_rv=%0b d_rv=%0b req=%0b, want 0 0 0", s_if_rv, s_d_rv, s_req);
        else
            n_pass++;
        cycle();   // cycle 2
        n_checks++;
        if (s_if_rv !== 1'b1 || s_d_rv !== 1'b0)
            $display("FAIL fetch_rvalid: if_rv=%0b d_rv=%0b, want 1 0", s_if_rv, s_d_rv);
        else
            n_pass++;
    endtask

    task automatic test_contention();
        logic seen  = 1'b0;
        logic early = 1'b0;
        rsp_lat = 3;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'b0101;
        d_addr  = 32'h0000_1004;
        cycle();
        n_checks++;
        if (!(s_d_gnt === 1'b1 && s_if_gnt === 1'b0 && s_addr === 32'h0000_1004 &&
              s_be === 4'b1111 && s_we === 1'b0))
            $display("FAIL cont_first: d_gnt=%0b if_gnt=%0b addr=%h be=%b we=%0b, want 1 0 00001004 1111 0",
                     s_d_gnt, s_if_gnt, s_addr, s_be, s_we);
        else
            n_pass++;
        if (s_d_gnt) sb.push_back('{owner: 1'b1, data: mem_model(32'h0000_1004)});
        d_req = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (s_if_gnt) early = 1'b1;
            if (s_d_rv) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1 || early !== 1'b0)
            $display("FAIL cont_wait: d_rvalid_seen=%0b early_if_gnt=%0b, want 1 0", seen, early);
        else
            n_pass++;
        cycle();
        n_checks++;
        if (s_if_gnt !== 1'b1 || s_addr !== 32'h0000_0300)
            $display("FAIL cont_second: if_gnt=%0b addr=%h, want 1 00000300", s_if_gnt, s_addr);
        else
            n_pass++;
        if (s_if_gnt) sb.push_back('{owner: 1'b0, data: mem_model(32'h0000_0300)});
        if_req = 1'b0;
        drain(10);
    endtask

    task automatic test_write_stream();
        logic any_rv = 1'b0;
        d_req = 1'b1;
        d_we  = 1'b1;
        d_be  = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            d_addr  = 32'h0000_2000 + 32'(4 * i);
            d_wdata = 32'h1111_1111 * 32'(i + 1);
            cycle();
            any_rv = any_rv | s_if_rv | s_d_rv;
            n_checks++;
            if (!(s_d_gnt === 1'b1 && s_if_gnt === 1'b0 && s_req === 1'b1 && s_we === 1'b1 &&
                  s_be === 4'b0011 && s_addr === 32'h0000_2000 + 32'(4 * i) &&
                  s_wdata === 32'h1111_1111 * 32'(i + 1)))
                $display("FAIL write_%0d: d_gnt=%0b req=%0b we=%0b be=%b addr=%h wdata=%h, want 1 1 1 0011 %h %h",
                         i, s_d_gnt, s_req, s_we, s_be, s_addr, s_wdata,
                         32'h0000_2000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            else
                n_pass++;
        end
        mem_ready = 1'b0;
        d_addr    = 32'h0000_2010;
        d_wdata   = 32'hA5A5_A5A5;
        cycle();
        any_rv = any_rv | s_if_rv | s_d_rv;
        n_checks++;
        if (s_d_gnt !== 1'b0 || s_req !== 1'b0)
            $display("FAIL write_not_ready: d_gnt=%0b mem_req=%0b, want 0 0", s_d_gnt, s_req);
        else
            n_pass++;
        mem_ready = 1'b1;
        cycle();
        any_rv = any_rv | s_if_rv | s_d_rv;
        n_checks++;
        if (s_d_gnt !== 1'b1 || s_addr !== 32'h0000_2010 || s_wdata !== 32'hA5A5_A5A5)
            $display("FAIL write_resume: d_gnt=%0b addr=%h wdata=%h, want 1 00002010 a5a5a5a5",
                     s_d_gnt, s_addr, s_wdata);
        else
            n_pass++;
        d_req = 1'b0;
        d_we  = 1'b0;
        n_checks++;
        if (any_rv !== 1'b0) $display("FAIL write_rvalid: rvalid_seen=%0b, want 0", any_rv);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int   n_d    = 0;
        logic got_if = 1'b0;
        rsp_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b1111;
        for (int i = 0; i < 12 && !got_if; i++) begin
            d_addr  = 32'h0000_3000 + 32'(4 * i);
            d_wdata = 32'(i);
            cycle();
            if (s_if_gnt) got_if = 1'b1;
            else if (s_d_gnt) n_d++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        n_checks++;
        if (got_if !== 1'b1 || n_d != 4)
            $display("FAIL starve_guard: if_gnt_seen=%0b d_grants=%0d, want 1 4", got_if, n_d);
        else
            n_pass++;
        if (got_if) sb.push_back('{owner: 1'b0, data: mem_model(32'h0000_0400)});
        if_req = 1'b0;
        drain(10);
        cycle();
        n_checks++;
        if (s_d_gnt !== 1'b1) $display("FAIL starve_data_resume: d_gnt=%0b, want 1", s_d_gnt);
        else n_pass++;
        d_req = 1'b0;
        d_we  = 1'b0;
`else
        n_checks++;
        if (got_if !== 1'b0 || n_d != 12)
            $display("FAIL starve_strict: if_gnt_seen=%0b d_grants=%0d, want 0 12", got_if, n_d);
        else
            n_pass++;
        d_req = 1'b0;
        d_we  = 1'b0;
        cycle();
        n_checks++;
        if (s_if_gnt !== 1'b1 || s_addr !== 32'h0000_0400)
            $display("FAIL starve_release: if_gnt=%0b addr=%h, want 1 00000400", s_if_gnt, s_addr);
        else
            n_pass++;
        if (s_if_gnt) sb.push_back('{owner: 1'b0, data: mem_model(32'h0000_0400)});
        if_req = 1'b0;
        drain(10);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_be       = 4'b0000;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(posedge clk);
        #1;

        test_reset();
        test_single_fetch();
        test_contention();
        test_write_stream();
        test_starvation();

        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: pending=%0d, want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one single-port data/instruction memory between the core's instruction-fetch port and its load/store port. It sits between the CPU core and a unified memory. It serialises accesses, tracks the one outstanding read, and routes each read response back to the requester that issued it. Data accesses take priority over fetches, with an optional starvation guard for fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits (guard builds only).
- CNT_W, 3: width of the starvation counter. Must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address (word-aligned)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_be  in  4  write byte enables
- d_addr  in  32  data byte address (word-aligned)
- d_wdata  in  32  write data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  32  data read data
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables (4'b1111 on reads)
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory can accept mem_req this cycle
- mem_rvalid  in  1  read data returned (latency ≥1 cycle)
- mem_rdata  in  32  memory read data

## Operation
- FSM states:
  - IDLE: may grant.
  - RD_WAIT: one read outstanding. No grants.
- In IDLE with mem_ready=1, the arbiter picks one requester:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless the guard forces fetch.
- The grant drives mem_req=1 and muxes the winner's addr, we, be, and wdata onto the mem_* outputs in the same cycle.
- A write grant completes the access. The FSM stays in IDLE and no rvalid is produced.
- A read grant moves the FSM to RD_WAIT and latches the owner bit (0 = fetch, 1 = data).
- In RD_WAIT, on mem_rvalid=1:
  - Pulse the owner's rvalid for one cycle.
  - Drive the owner's rdata = mem_rdata.
  - Return to IDLE.
- mem_rvalid in IDLE is ignored and never forwarded.
- mem_ready=0 in IDLE means no grant. Requests stay pending.
- Fetch accesses are always reads: mem_we=0, mem_be=4'b1111.
- if_rdata and d_rdata both carry mem_rdata. Only the rvalid strobes are qualified.

## Timing
- Grants and the mem_* outputs are combinational from the requests, state and mem_ready.
- Zero-cycle issue latency: a request is granted in the cycle it is first seen, when IDLE and mem_ready=1.
- rvalid is combinational from mem_rvalid.
- Back-to-back:
  - Writes: one per cycle.
  - Reads: one per (memory latency + 1) cycles. No grant in the cycle mem_rvalid returns; the next grant is possible the cycle after.
- During reset, and out of reset while idle with no requests, every output is 0: all gnt, all rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata. rdata outputs follow mem_rdata.
- Reset asserted mid-read:
  - FSM returns to IDLE; owner and counter clear.
  - The late mem_rvalid is dropped.
- A request deasserted before its grant is a protocol violation. The behaviour is unspecified.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A CNT_W counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant, or whenever if_req=0.
  - When the counter equals STARVE_LIMIT and both requests are present, fetch wins.
- Not defined: strict data priority, no counter logic. Fetch can starve indefinitely.

## Test plan
- Reset: rst_n=0 mid-RD_WAIT, mem_rvalid=1 one cycle after release -> no rvalid pulse, all outputs 0, FSM in IDLE.
- Single fetch: if_req, if_addr=0x100, memory latency 2 -> if_gnt and mem_req in cycle 0; mem_addr=0x100; if_rvalid pulse in cycle 2 with if_rdata=0xDEADBEEF; no d_rvalid.
- Contention: if_req and d_req (read 0x1004) both asserted -> d_gnt first; if_gnt granted the cycle after d_rvalid.
- Write stream: d_req/d_we=1 for 4 cycles, d_be=4'b0011 -> d_gnt every cycle, mem_we=1, mem_be=4'b0011, no rvalid; mem_ready=0 for one cycle -> no grant that cycle.
- Starvation (macro on, STARVE_LIMIT=4): if_req held, d_req writes continuous -> exactly 4 d_gnt, then if_gnt; with macro off -> if_gnt never until d_req drops.
